// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants and decode helpers for the display driver and capture monitor.
// Latency: combinational helpers only, no state.
// Backpressure: not applicable (constants and pure functions).
//
// Contents:
//   SEG_CODE[16]  active-low g..a patterns for hex digits 0..F (DP not included)
//   DIG_SEL[4]    active-low one-hot digit enables, index = digit position
//   seg_to_nibble decode a 7-bit active-low pattern to {ok, nibble}
//   dig_to_pos    decode a digit-enable vector to {ok, position}
package seven_seg_pkg;

  // Active-low segment patterns, bit6=g ... bit0=a.
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A B
    7'h46, 7'h21, 7'h06, 7'h0E    // C D E F
  };

  // Active-low one-hot digit enables; DIG_SEL[0] selects digit0 (rightmost).
  localparam logic [3:0] DIG_SEL [4] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } seg_dec_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] pos;
  } dig_dec_t;

  // Reverse lookup of the segment table. Unknown patterns return ok=0, nib=0.
  function automatic seg_dec_t seg_to_nibble(input logic [6:0] pattern);
    seg_dec_t res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_CODE[i]) begin
        res.ok  = 1'b1;
        res.nib = 4'(i);
      end
    end
    return res;
  endfunction

  // Anything that is not exactly one low bit is treated as a blanked display.
  function automatic dig_dec_t dig_to_pos(input logic [3:0] enables);
    dig_dec_t res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      if (enables == DIG_SEL[i]) begin
        res.ok  = 1'b1;
        res.pos = 2'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seven_seg_capture.sv
// Receive side of a 4-digit multiplexed seven-segment bus: settle, decode, reassemble 16-bit value.
// Latency: last-digit input edge -> num_valid = 2 (sync) + SETTLE_CYC (settle) + 1 (completion) cycles.
// Backpressure: none; a passive monitor, results are single-cycle pulses plus a held disp_num.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   dig[3:0]   active-low one-hot digit enables (0111 = digit3 ... 1110 = digit0)
//   seg[7:0]   active-low segment lines, bit7 = DP, bits6:0 = g..a
//   disp_num   last complete, error-free frame; digit3 -> [15:12] ... digit0 -> [3:0]
//   num_valid  1-cycle pulse when disp_num is updated
//   pat_err    1-cycle pulse when a settled digit shows an undecodable pattern
//   frame_err  1-cycle pulse when a completed frame is dropped because of a bad digit
//   active     high while captures keep arriving within TIMEOUT_CYC of each other
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  dig,
  input  logic [7:0]  seg,
  output logic [15:0] disp_num,
  output logic        num_valid,
  output logic        pat_err,
  output logic        frame_err,
  output logic        active
);

  localparam int CNT_W = (SETTLE_CYC  > 2) ? $clog2(SETTLE_CYC)  : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  // The stability counter saturates at SETTLE_CYC-1; the capture decision is
  // taken one count earlier so the capture registers on the same edge the
  // counter reaches SETTLE_CYC-1, i.e. after SETTLE_CYC equal samples.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(SETTLE_CYC - 2);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_PRE  = TO_W'(TIMEOUT_CYC - 2);

  // ------------------------------------------------------------------
  // Input synchronizer and stability tracking
  // ------------------------------------------------------------------
  logic [11:0]      sync1;
  logic [11:0]      sync2;
  logic [11:0]      prev;
  logic [CNT_W-1:0] stab_cnt;
  logic             armed;

  logic             same;
  logic             capture;
  dig_dec_t         dpos;
  seg_dec_t         sdec;

  // DP (sync2[7]) takes part in the stability compare, so toggling only the
  // DP restarts the settle window even though it never affects the value.
  assign same = (sync2 == prev);
  assign dpos = dig_to_pos(sync2[11:8]);
  assign sdec = seg_to_nibble(sync2[6:0]);

  // Blanked enables (not one-hot-low) let the counter run but never capture.
  assign capture = same && armed && (stab_cnt == CNT_PRE) && dpos.ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      stab_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      sync1 <= {dig, seg};
      sync2 <= sync1;
      prev  <= sync2;
      if (!same) begin
        stab_cnt <= '0;
        armed    <= 1'b1;
      end else begin
        if (stab_cnt != CNT_MAX) begin
          stab_cnt <= stab_cnt + 1'b1;
        end
        // One capture per steady pattern; re-armed only by a change.
        if (capture) begin
          armed <= 1'b0;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Timeout / activity tracking
  // ------------------------------------------------------------------
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;

  // Fires once as the counter steps onto TO_MAX, then the counter parks
  // there. A capture in the same cycle takes priority.
  assign timeout_hit = !capture && (to_cnt == TO_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      active <= 1'b0;
    end else begin
      if (capture) begin
        to_cnt <= '0;
        active <= 1'b1;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
        if (timeout_hit) begin
          active <= 1'b0;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Frame assembly
  // ------------------------------------------------------------------
  logic [3:0][3:0] shadow;
  logic [3:0]      mask;
  logic [3:0]      bad;
  logic            frame_done;

  assign frame_done = (mask == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      mask      <= '0;
      bad       <= '0;
      disp_num  <= '0;
      num_valid <= 1'b0;
      pat_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      num_valid <= 1'b0;
      pat_err   <= 1'b0;
      frame_err <= 1'b0;

      if (frame_done) begin
        mask <= '0;
        bad  <= '0;
        if (bad == 4'h0) begin
          disp_num  <= shadow;
          num_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end else if (timeout_hit) begin
        mask <= '0;
        bad  <= '0;
      end

      // Placed after the clears so a capture landing in a clearing cycle
      // still records its own position (later non-blocking write wins).
      // Recapturing a position mid-frame overwrites nibble and bad flag.
      if (capture) begin
        shadow[dpos.pos] <= sdec.ok ? sdec.nib : 4'h0;
        mask[dpos.pos]   <= 1'b1;
        bad[dpos.pos]    <= ~sdec.ok;
        pat_err          <= ~sdec.ok;
      end
    end
  end

endmodule
